// File: rtl/mem_pkg.sv
// Shared types for the memory copy/fill engine: FSM states, operation codes
// and the default data/address width.
package mem_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-granular memcpy / memset engine driving a single-port RAM with
// combinational read data. COPY alternates READ/WRITE per word; FILL writes every cycle.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned ADDR_MAX = 1024
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] SRC,
  input  logic [WIDTH-1:0] DST,
  input  logic [WIDTH-1:0] LEN,
  input  logic [WIDTH-1:0] FILL_VAL,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_ADDRESS,
  output logic [WIDTH-1:0] MEM_WD,
  input  logic [WIDTH-1:0] MEM_RD
);

  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(ADDR_MAX);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   dst_last;
  logic [WIDTH:0]   src_last;
  logic             range_bad;

  // One extra bit so a wrapping end address is caught as out of range.
  always_comb begin
    dst_last  = {1'b0, DST} + {1'b0, LEN} - (WIDTH+1)'(1);
    src_last  = {1'b0, SRC} + {1'b0, LEN} - (WIDTH+1)'(1);
    range_bad = (LEN != '0) &&
                ((dst_last > LIMIT) || ((op_t'(OP) == OP_COPY) && (src_last > LIMIT)));
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= OP_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    fill_d      = fill_q;
    data_d      = data_q;
    idx_d       = idx_q;
    err_d       = 1'b0;
    BUSY        = (state_q != IDLE);
    DONE        = 1'b0;
    MEM_WE      = 1'b0;
    MEM_ADDRESS = '0;
    MEM_WD      = '0;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else begin
            op_d   = op_t'(OP);
            src_d  = SRC;
            dst_d  = DST;
            len_d  = LEN;
            fill_d = FILL_VAL;
            idx_d  = '0;
            if (LEN == '0)                  state_d = FINISH;
            else if (op_t'(OP) == OP_COPY)  state_d = READ;
            else                            state_d = WRITE;
          end
        end
      end
      READ: begin
        MEM_ADDRESS = src_q + idx_q;
        data_d      = MEM_RD;
        state_d     = WRITE;
      end
      WRITE: begin
        MEM_WE      = 1'b1;
        MEM_ADDRESS = dst_q + idx_q;
        MEM_WD      = (op_q == OP_COPY) ? data_q : fill_q;
        if (idx_q == len_q - WIDTH'(1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + WIDTH'(1);
          state_d = (op_q == OP_COPY) ? READ : WRITE;
        end
      end
      FINISH: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ERROR = err_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench: engine attached to a 1025-word RAM model, words 0..63 = index,
// remaining words a recognisable background pattern.
module tb_mem_copy_engine;

  localparam int unsigned W     = 32;
  localparam int unsigned WORDS = 1025;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         OP = 1'b0;
  logic [W-1:0] SRC = '0, DST = '0, LEN = '0, FILL_VAL = '0;
  logic         BUSY, DONE, ERROR, MEM_WE;
  logic [W-1:0] MEM_ADDRESS, MEM_WD, MEM_RD;

  logic [W-1:0] ram [WORDS];
  int           we_count = 0;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_copy_engine #(.WIDTH(W), .ADDR_MAX(1024)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP),
    .SRC(SRC), .DST(DST), .LEN(LEN), .FILL_VAL(FILL_VAL),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .MEM_WE(MEM_WE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  function automatic logic [W-1:0] init_word(int i);
    return (i < 64) ? W'(i) : (32'h5A5A_0000 + W'(i));
  endfunction

  initial begin
    for (int i = 0; i < int'(WORDS); i++) ram[i] = init_word(i);
  end

  assign MEM_RD = (MEM_ADDRESS < W'(WORDS)) ? ram[MEM_ADDRESS[10:0]] : '0;

  always @(posedge CLK) begin
    if (MEM_WE) begin
      we_count <= we_count + 1;
      if (MEM_ADDRESS < W'(WORDS)) ram[MEM_ADDRESS[10:0]] <= MEM_WD;
    end
  end

  // Acceptance edge is the posedge right after this task raises START;
  // inputs are scrambled afterwards so only registered values may be used.
  task automatic issue(input logic op, input logic [W-1:0] src, input logic [W-1:0] dst,
                       input logic [W-1:0] len, input logic [W-1:0] fv);
    @(negedge CLK);
    OP = op; SRC = src; DST = dst; LEN = len; FILL_VAL = fv; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; OP = ~op; SRC = 32'd999; DST = 32'd999; LEN = 32'd999; FILL_VAL = 32'h0BAD_0BAD;
  endtask

  // Cycle n is the one sampled at the n-th negedge after the acceptance edge.
  task automatic wait_done(output int cyc, output logic busy_at_done);
    cyc = -1;
    busy_at_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        cyc = c;
        busy_at_done = BUSY;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({BUSY, DONE, ERROR, MEM_WE, MEM_ADDRESS, MEM_WD} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b we=%b addr=%h wd=%h, required all 0",
               BUSY, DONE, ERROR, MEM_WE, MEM_ADDRESS, MEM_WD);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_copy();
    int cyc; logic b; int we0;
    we0 = we_count;
    issue(1'b0, 32'd0, 32'd100, 32'd8, 32'h0);
    wait_done(cyc, b);
    n_checks++;
    if (cyc != 17) begin n_fail++; $display("FAIL copy_done_cycle: got %0d, required 17", cyc); end
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL copy_busy_finish: got %b, required 1", b); end
    n_checks++;
    if (we_count - we0 != 8) begin n_fail++; $display("FAIL copy_write_count: got %0d, required 8", we_count - we0); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ram[100+i] !== W'(i)) begin n_fail++; $display("FAIL copy_dst[%0d]: got %h, required %h", 100+i, ram[100+i], W'(i)); end
      n_checks++;
      if (ram[i] !== W'(i)) begin n_fail++; $display("FAIL copy_src[%0d]: got %h, required %h", i, ram[i], W'(i)); end
    end
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL copy_busy_after: got %b, required 0", BUSY); end
  endtask

  task automatic test_fill();
    int cyc; logic b;
    issue(1'b1, 32'd0, 32'd200, 32'd4, 32'hDEAD_BEEF);
    wait_done(cyc, b);
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("FAIL fill_done_cycle: got %0d, required 5", cyc); end
    for (int i = 200; i < 204; i++) begin
      n_checks++;
      if (ram[i] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fill_word[%0d]: got %h, required deadbeef", i, ram[i]); end
    end
    n_checks++;
    if (ram[199] !== init_word(199)) begin n_fail++; $display("FAIL fill_below: got %h, required %h", ram[199], init_word(199)); end
    n_checks++;
    if (ram[204] !== init_word(204)) begin n_fail++; $display("FAIL fill_above: got %h, required %h", ram[204], init_word(204)); end
  endtask

  task automatic test_zero_len();
    int cyc; logic b; int we0;
    we0 = we_count;
    issue(1'b0, 32'd5, 32'd50, 32'd0, 32'h0);
    wait_done(cyc, b);
    n_checks++;
    if (cyc != 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d, required 1", cyc); end
    n_checks++;
    if (b !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b, required 1", b); end
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b, required 0", BUSY); end
    n_checks++;
    if (we_count != we0) begin n_fail++; $display("FAIL zero_writes: got %0d, required 0", we_count - we0); end
  endtask

  task automatic test_range_error();
    int cyc; logic b; int we0; logic busy_seen;
    we0 = we_count;
    busy_seen = 1'b0;
    issue(1'b1, 32'd0, 32'd1020, 32'd8, 32'h1234_5678);
    @(negedge CLK);
    n_checks++;
    if (ERROR !== 1'b1) begin n_fail++; $display("FAIL range_error_pulse: got %b, required 1", ERROR); end
    busy_seen = BUSY;
    @(negedge CLK);
    n_checks++;
    if (ERROR !== 1'b0) begin n_fail++; $display("FAIL range_error_width: got %b, required 0", ERROR); end
    busy_seen = busy_seen | BUSY;
    repeat (3) begin @(negedge CLK); busy_seen = busy_seen | BUSY; end
    n_checks++;
    if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL range_busy: got %b, required 0", busy_seen); end
    n_checks++;
    if (we_count != we0) begin n_fail++; $display("FAIL range_writes: got %0d, required 0", we_count - we0); end

    issue(1'b1, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'h1234_5678);
    @(negedge CLK);
    n_checks++;
    if (ERROR !== 1'b1) begin n_fail++; $display("FAIL range_overflow: got %b, required 1", ERROR); end

    issue(1'b0, 32'd1020, 32'd0, 32'd8, 32'h0);
    @(negedge CLK);
    n_checks++;
    if (ERROR !== 1'b1) begin n_fail++; $display("FAIL range_src: got %b, required 1", ERROR); end
    n_checks++;
    if (we_count != we0) begin n_fail++; $display("FAIL range_writes2: got %0d, required 0", we_count - we0); end

    // Last word exactly at ADDR_MAX is legal.
    issue(1'b1, 32'd0, 32'd1017, 32'd8, 32'hCAFE_F00D);
    wait_done(cyc, b);
    n_checks++;
    if (cyc != 9) begin n_fail++; $display("FAIL range_edge_done: got %0d, required 9", cyc); end
    n_checks++;
    if (ram[1024] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL range_edge_word: got %h, required cafef00d", ram[1024]); end
  endtask

  task automatic test_reset_mid_copy();
    int we_at_reset;
    issue(1'b0, 32'd0, 32'd300, 32'd16, 32'h0);
    repeat (10) @(negedge CLK);  // cycle 10 is the 5th WRITE
    n_checks++;
    if (MEM_WE !== 1'b1) begin n_fail++; $display("FAIL midrst_fifth_write: got we=%b, required 1", MEM_WE); end
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (MEM_WE !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b, required 0", MEM_WE); end
    we_at_reset = we_count;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    n_checks++;
    if (we_count != we_at_reset || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: writes after reset=%0d busy=%b, required 0 and 0", we_count - we_at_reset, BUSY);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram[300+i] !== W'(i)) begin n_fail++; $display("FAIL midrst_done[%0d]: got %h, required %h", 300+i, ram[300+i], W'(i)); end
    end
    for (int i = 305; i <= 315; i++) begin
      n_checks++;
      if (ram[i] !== init_word(i)) begin n_fail++; $display("FAIL midrst_untouched[%0d]: got %h, required %h", i, ram[i], init_word(i)); end
    end
  endtask

  task automatic test_start_while_busy();
    int we0; int cyc;
    we0 = we_count;
    cyc = -1;
    issue(1'b1, 32'd0, 32'd400, 32'd4, 32'h1111_1111);
    @(negedge CLK);
    OP = 1'b1; DST = 32'd500; LEN = 32'd4; FILL_VAL = 32'h2222_2222; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 3; c <= 60; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin cyc = c; break; end
    end
    repeat (10) @(negedge CLK);
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("FAIL busy_start_done: got %0d, required 5", cyc); end
    n_checks++;
    if (we_count - we0 != 4) begin n_fail++; $display("FAIL busy_start_writes: got %0d, required 4", we_count - we0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram[400+i] !== 32'h1111_1111) begin n_fail++; $display("FAIL busy_first[%0d]: got %h, required 11111111", 400+i, ram[400+i]); end
      n_checks++;
      if (ram[500+i] !== init_word(500+i)) begin n_fail++; $display("FAIL busy_second[%0d]: got %h, required %h", 500+i, ram[500+i], init_word(500+i)); end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_zero_len();
    test_range_error();
    test_reset_mid_copy();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter ADDR_MAX, default 1024: highest legal word address.
REQ-003 SHALL have port CLK  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port RST_N  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1: command request, sampled only in IDLE.
REQ-006 SHALL have port OP  input  1: 0 = COPY, 1 = FILL.
REQ-007 SHALL have port SRC  input  WIDTH: COPY source base word address.
REQ-008 SHALL have port DST  input  WIDTH: destination base word address.
REQ-009 SHALL have port LEN  input  WIDTH: word count.
REQ-010 SHALL have port FILL_VAL  input  WIDTH: FILL data word.
REQ-011 SHALL have port BUSY  output  1: command in progress.
REQ-012 SHALL have port DONE  output  1: one-cycle completion pulse.
REQ-013 SHALL have port ERROR  output  1: one-cycle range-violation pulse.
REQ-014 SHALL have port MEM_WE  output  1: RAM write enable.
REQ-015 SHALL have port MEM_ADDRESS  output  WIDTH: RAM word address.
REQ-016 SHALL have port MEM_WD  output  WIDTH: RAM write data.
REQ-017 SHALL have port MEM_RD  input  WIDTH: RAM read data, combinational from MEM_ADDRESS in the same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, FINISH.
REQ-019 SHALL register SRC, DST, LEN, OP and FILL_VAL on the accepting edge; later changes to these inputs SHALL have no effect.
REQ-020 SHALL check range on START acceptance in IDLE: if LEN != 0 and DST+LEN-1 > ADDR_MAX, or if OP=COPY and SRC+LEN-1 > ADDR_MAX, then pulse ERROR next cycle, issue no writes, and stay in IDLE; sums SHALL be computed at WIDTH+1 bits so overflow counts as a violation.
REQ-021 SHALL, with LEN=0 and no violation, go to FINISH, issue no writes, and pulse DONE one cycle after acceptance.
REQ-022 SHALL, for COPY, loop READ -> WRITE per word: READ drives MEM_ADDRESS=SRC+i, MEM_WE=0 and captures MEM_RD; WRITE drives MEM_ADDRESS=DST+i, MEM_WD=captured word, MEM_WE=1.
REQ-023 SHALL, for FILL, stay in WRITE, driving MEM_ADDRESS=DST+i, MEM_WD=FILL_VAL, MEM_WE=1 every cycle.
REQ-024 SHALL process words in ascending index i=0..LEN-1; overlapping regions are not corrected (COPY is memcpy, not memmove).
REQ-025 SHALL take exactly 2*LEN cycles from acceptance to the last write for COPY, and LEN cycles for FILL.
REQ-026 SHALL enter FINISH after the last write; FINISH pulses DONE for one cycle and returns to IDLE.
REQ-027 SHALL hold BUSY=1 from the cycle after acceptance through FINISH inclusive.
REQ-028 SHALL ignore START while not in IDLE; START held high SHALL begin a new command on the first IDLE cycle.
REQ-029 SHALL drive MEM_WE=1 only in WRITE state.

Reset
REQ-030 SHALL, with RST_N low at a rising edge, move the FSM to IDLE and clear BUSY, DONE, ERROR, MEM_WE, MEM_ADDRESS and MEM_WD to 0, discarding any command.
REQ-031 SHALL, on reset mid-command, issue no write after the reset edge; words already written remain.

Structure
REQ-032 SHALL place the state enum, the op enum (OP_COPY, OP_FILL) and the WIDTH default in shared package mem_pkg.
REQ-033 SHALL contain no sub-module; the bench SHALL connect the engine to the existing RAM block (WIDTH=32, 1025 words, words 0..63 preloaded with value = index).

Verification
REQ-034 SHALL verify: COPY SRC=0 DST=100 LEN=8 -> RAM[100..107]=0..7; DONE exactly 17 cycles after acceptance; RAM[0..7] unchanged.
REQ-035 SHALL verify: FILL DST=200 LEN=4 FILL_VAL=0xDEADBEEF -> RAM[200..203]=0xDEADBEEF; DONE 5 cycles after acceptance; RAM[199] and RAM[204] unchanged.
REQ-036 SHALL verify: LEN=0 -> no MEM_WE; DONE 1 cycle after acceptance; BUSY high for that one cycle.
REQ-037 SHALL verify: FILL DST=1020 LEN=8 -> ERROR pulse, no MEM_WE, BUSY stays 0; then DST=0xFFFFFFFF LEN=2 -> ERROR (overflow case).
REQ-038 SHALL verify: COPY SRC=0 DST=300 LEN=16, RST_N low during the 5th WRITE -> MEM_WE=0 from the reset edge; RAM[300..303]=0..3; RAM[305..315] unchanged.
REQ-039 SHALL verify: START pulsed while BUSY -> ignored; only the first command is performed.
